// File: rtl/spi_reg_pkg.sv
// Shared constants, frame layout and FSM state type for the SPI register bank.
package spi_reg_pkg;

    localparam int unsigned FRAME_BITS = 16;
    localparam int unsigned MAX_ADDR   = 4;
    localparam int unsigned ADDR_W     = 7;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned CNT_W      = 5;
    localparam int unsigned ERR_W      = 8;

    localparam logic [ADDR_W-1:0] ADDR_EN_OUT_LO = 7'd0;
    localparam logic [ADDR_W-1:0] ADDR_EN_OUT_HI = 7'd1;
    localparam logic [ADDR_W-1:0] ADDR_EN_PWM_LO = 7'd2;
    localparam logic [ADDR_W-1:0] ADDR_EN_PWM_HI = 7'd3;
    localparam logic [ADDR_W-1:0] ADDR_DUTY      = 7'd4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        OVERRUN = 2'd2
    } state_e;

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } frame_t;

endpackage

// File: rtl/spi_reg_bank_if.sv
// SPI pin bundle: the host drives it (master), the register bank samples it (slave).
interface spi_reg_bank_if;
    logic nCS_in;
    logic COPI_in;
    logic SCLK_in;

    modport master (output nCS_in, output COPI_in, output SCLK_in);
    modport slave  (input  nCS_in, input  COPI_in, input  SCLK_in);
endinterface

// File: rtl/spi_reg_bank_sync_edge.sv
// Multi-flop synchronizer with a history flop for rise/fall detection.
module sync_edge #(
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_in,
    output logic sync_out,
    output logic rise_c,
    output logic fall_c
);
    logic [STAGES-1:0] sync_q, sync_d;
    logic              hist_q, hist_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d_in};
        hist_d = sync_q[STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RST_VAL}};
            hist_q <= RST_VAL;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    assign sync_out = sync_q[STAGES-1];
    assign rise_c   = sync_q[STAGES-1] & ~hist_q;
    assign fall_c   = ~sync_q[STAGES-1] & hist_q;
endmodule

// File: rtl/spi_reg_bank.sv
// SPI Mode-0 write-only bank of five PWM control registers with error accounting.
module spi_reg_bank
    import spi_reg_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    spi_reg_bank_if.slave        spi,
    output logic [DATA_W-1:0]    en_reg_out_7_0,
    output logic [DATA_W-1:0]    en_reg_out_15_8,
    output logic [DATA_W-1:0]    en_reg_pwm_7_0,
    output logic [DATA_W-1:0]    en_reg_pwm_15_8,
    output logic [DATA_W-1:0]    pwm_duty_cycle,
    output logic                 wr_pulse,
    output logic                 err_pulse,
    output logic [ERR_W-1:0]     err_count
);
    logic ncs_sync, ncs_rise, ncs_fall;
    logic sclk_sync, sclk_rise, sclk_fall;
    logic copi_sync, copi_rise, copi_fall;
    logic unused_edges;

    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
        .clk(clk), .rst_n(rst_n), .d_in(spi.nCS_in),
        .sync_out(ncs_sync), .rise_c(ncs_rise), .fall_c(ncs_fall));
    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .d_in(spi.SCLK_in),
        .sync_out(sclk_sync), .rise_c(sclk_rise), .fall_c(sclk_fall));
    sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
        .clk(clk), .rst_n(rst_n), .d_in(spi.COPI_in),
        .sync_out(copi_sync), .rise_c(copi_rise), .fall_c(copi_fall));

    assign unused_edges = &{1'b0, ncs_sync, sclk_sync, sclk_fall, copi_rise, copi_fall};

    state_e                  state_q, state_d;
    logic [FRAME_BITS-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0]       out_lo_q, out_lo_d, out_hi_q, out_hi_d;
    logic [DATA_W-1:0]       pwm_lo_q, pwm_lo_d, pwm_hi_q, pwm_hi_d;
    logic [DATA_W-1:0]       duty_q, duty_d;
    logic                    wr_q, wr_d, err_q, err_d;
    logic [ERR_W-1:0]        err_cnt_q, err_cnt_d;
    frame_t                  frm_c;
    logic                    accept_c;

    assign frm_c    = shift_q;
    assign accept_c = (cnt_q == CNT_W'(FRAME_BITS)) && frm_c.wr
                      && (frm_c.addr <= ADDR_W'(MAX_ADDR));

    // Next-state, register commit and strobe generation.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        out_lo_d  = out_lo_q;
        out_hi_d  = out_hi_q;
        pwm_lo_d  = pwm_lo_q;
        pwm_hi_d  = pwm_hi_q;
        duty_d    = duty_q;
        wr_d      = 1'b0;
        err_d     = 1'b0;
        err_cnt_d = err_cnt_q;
        case (state_q)
            IDLE: begin
                if (ncs_fall) begin
                    shift_d = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // nCS release takes priority over a coincident SCLK rise.
                if (ncs_rise) begin
                    state_d = IDLE;
                    if (accept_c) begin
                        wr_d = 1'b1;
                        case (frm_c.addr)
                            ADDR_EN_OUT_LO: out_lo_d = frm_c.data;
                            ADDR_EN_OUT_HI: out_hi_d = frm_c.data;
                            ADDR_EN_PWM_LO: pwm_lo_d = frm_c.data;
                            ADDR_EN_PWM_HI: pwm_hi_d = frm_c.data;
                            ADDR_DUTY:      duty_d   = frm_c.data;
                            default: ;
                        endcase
                    end else begin
                        err_d = 1'b1;
                        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_W'(1);
                    end
                end else if (sclk_rise) begin
                    if (cnt_q == CNT_W'(FRAME_BITS)) begin
                        state_d = OVERRUN;
                    end else begin
                        shift_d = {shift_q[FRAME_BITS-2:0], copi_sync};
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
            end
            OVERRUN: begin
                if (ncs_rise) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                    if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            cnt_q     <= '0;
            out_lo_q  <= '0;
            out_hi_q  <= '0;
            pwm_lo_q  <= '0;
            pwm_hi_q  <= '0;
            duty_q    <= '0;
            wr_q      <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            out_lo_q  <= out_lo_d;
            out_hi_q  <= out_hi_d;
            pwm_lo_q  <= pwm_lo_d;
            pwm_hi_q  <= pwm_hi_d;
            duty_q    <= duty_d;
            wr_q      <= wr_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign en_reg_out_7_0  = out_lo_q;
    assign en_reg_out_15_8 = out_hi_q;
    assign en_reg_pwm_7_0  = pwm_lo_q;
    assign en_reg_pwm_15_8 = pwm_hi_q;
    assign pwm_duty_cycle  = duty_q;
    assign wr_pulse        = wr_q;
    assign err_pulse       = err_q;
    assign err_count       = err_cnt_q;
endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed bench for spi_reg_bank with a frame-level reference model checked every cycle.
module tb_spi_reg_bank;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8;
    logic [7:0] pwm_duty_cycle, err_count;
    logic       wr_pulse, err_pulse;

    spi_reg_bank_if spi_if ();

    spi_reg_bank dut (
        .clk(clk), .rst_n(rst_n), .spi(spi_if),
        .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
        .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
        .pwm_duty_cycle(pwm_duty_cycle), .wr_pulse(wr_pulse),
        .err_pulse(err_pulse), .err_count(err_count));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model state: five registers, error counter, expected strobes.
    logic [7:0] m_reg [5];
    logic [7:0] m_err;
    logic       m_wr, m_ep;
    bit         m_bits [$];
    bit         pend_valid;
    int         pend_due;
    bit         pend_acc;
    int         pend_addr;
    logic [7:0] pend_data;

    function automatic void check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %02h expected %02h", name, cyc, act, exp);
        end
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 5; i++) m_reg[i] = 8'h00;
        m_err = 8'h00;
        m_bits.delete();
        pend_valid = 1'b0;
    endtask

    // Runs forever: applies due model outcomes and compares all outputs each cycle.
    task automatic compare_loop();
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            m_wr = 1'b0;
            m_ep = 1'b0;
            if (pend_valid && cyc == pend_due) begin
                pend_valid = 1'b0;
                if (pend_acc) begin
                    m_reg[pend_addr] = pend_data;
                    m_wr = 1'b1;
                end else begin
                    m_ep = 1'b1;
                    if (m_err != 8'hFF) m_err = m_err + 8'd1;
                end
            end
            check("en_reg_out_7_0",  en_reg_out_7_0,  m_reg[0]);
            check("en_reg_out_15_8", en_reg_out_15_8, m_reg[1]);
            check("en_reg_pwm_7_0",  en_reg_pwm_7_0,  m_reg[2]);
            check("en_reg_pwm_15_8", en_reg_pwm_15_8, m_reg[3]);
            check("pwm_duty_cycle",  pwm_duty_cycle,  m_reg[4]);
            check("wr_pulse",  {7'd0, wr_pulse},  {7'd0, m_wr});
            check("err_pulse", {7'd0, err_pulse}, {7'd0, m_ep});
            check("err_count", err_count, m_err);
        end
    endtask

    task automatic wait_neg(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic ncs_low();
        @(negedge clk);
        spi_if.nCS_in = 1'b0;
        m_bits.delete();
        wait_neg(4);
    endtask

    task automatic sclk_bit(input bit b);
        spi_if.COPI_in = b;
        spi_if.SCLK_in = 1'b0;
        wait_neg(4);
        spi_if.SCLK_in = 1'b1;
        m_bits.push_back(b);
        wait_neg(4);
    endtask

    // Release nCS; the model decides the frame's fate from the bits clocked in.
    task automatic ncs_high(input int settle);
        int n;
        int addr;
        logic [7:0] data;
        @(negedge clk);
        spi_if.nCS_in = 1'b1;
        n = m_bits.size();
        addr = 0;
        data = 8'h00;
        if (n == 16) begin
            for (int i = 1; i < 8; i++) addr = addr * 2 + int'(m_bits[i]);
            for (int i = 8; i < 16; i++) data = {data[6:0], m_bits[i]};
        end
        pend_acc   = (n == 16) && m_bits[0] && (addr <= 4);
        pend_addr  = addr;
        pend_data  = data;
        pend_due   = cyc + 3;
        pend_valid = 1'b1;
        wait_neg(settle);
    endtask

    task automatic send(input logic [15:0] w, input int n);
        ncs_low();
        for (int i = 0; i < n; i++) sclk_bit(i < 16 ? w[15-i] : 1'b1);
        ncs_high(6);
    endtask

    initial begin
        rst_n = 1'b0;
        spi_if.nCS_in  = 1'b1;
        spi_if.SCLK_in = 1'b0;
        spi_if.COPI_in = 1'b0;
        model_reset();
        m_wr = 1'b0;
        m_ep = 1'b0;
        fork
            compare_loop();
        join_none
        wait_neg(3);
        rst_n = 1'b1;
        wait_neg(2);
        check("reset err_count", err_count, 8'h00);
        check("reset duty", pwm_duty_cycle, 8'h00);

        // First write with explicit latency probing on edges 1..3 after release.
        ncs_low();
        for (int i = 0; i < 16; i++) begin
            logic [15:0] w;
            w = 16'h80F0;
            sclk_bit(w[15-i]);
        end
        ncs_high(0);
        @(posedge clk); #2;
        check("lat edge1 reg", en_reg_out_7_0, 8'h00);
        @(posedge clk); #2;
        check("lat edge2 wr", {7'd0, wr_pulse}, 8'h00);
        @(posedge clk); #2;
        check("lat edge3 reg", en_reg_out_7_0, 8'hF0);
        check("lat edge3 wr", {7'd0, wr_pulse}, 8'h01);
        @(posedge clk); #2;
        check("wr width", {7'd0, wr_pulse}, 8'h00);
        wait_neg(4);

        send(16'h8480, 16);
        send(16'h83AA, 16);
        check("duty after write", pwm_duty_cycle, 8'h80);
        check("pwm_hi after write", en_reg_pwm_15_8, 8'hAA);
        check("err after writes", err_count, 8'h00);

        send(16'h8555, 16);
        send(16'h0012, 16);
        send(16'h8001, 15);
        check("err after 3 bad", err_count, 8'h03);
        check("out_lo kept", en_reg_out_7_0, 8'hF0);

        send(16'h8111, 17);
        check("overrun out_hi", en_reg_out_15_8, 8'h00);
        check("overrun err", err_count, 8'h04);

        // Reset mid-frame, then finish the frame with nCS still low.
        ncs_low();
        for (int i = 0; i < 8; i++) begin
            logic [15:0] w;
            w = 16'h8222;
            sclk_bit(w[15-i]);
        end
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        wait_neg(2);
        rst_n = 1'b1;
        wait_neg(4);
        for (int i = 8; i < 16; i++) begin
            logic [15:0] w;
            w = 16'h8222;
            sclk_bit(w[15-i]);
        end
        ncs_high(6);
        check("post-reset pwm_lo", en_reg_pwm_7_0, 8'h00);
        check("post-reset out_lo", en_reg_out_7_0, 8'h00);
        send(16'h8233, 16);
        check("pwm_lo written", en_reg_pwm_7_0, 8'h33);

        for (int k = 0; k < 300; k++) begin
            ncs_low();
            ncs_high(4);
        end
        wait_neg(2);
        check("err saturated", err_count, 8'hFF);
        send(16'h8099, 16);
        check("write after sat", en_reg_out_7_0, 8'h99);
        send(16'h8099, 16);
        check("rewrite same", en_reg_out_7_0, 8'h99);
        check("err still sat", err_count, 8'hFF);

        wait_neg(4);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/spi_reg_bank.md
Name: spi_reg_bank

Overview:
SPI Mode-0 write-only register bank that sits directly upstream of the PWM peripheral.
- Samples the asynchronous nCS/COPI/SCLK pins on the system clock and shifts in 16-bit frames.
- On a valid frame, commits the data byte to one of five control registers: output enables, PWM enables and duty cycle.
- The registers drive the PWM peripheral combinationally; the block also exposes commit/error strobes and a saturating error counter.

Parameters:
- FRAME_BITS, 16, bits per valid frame (1 R/W + 7 address + 8 data).
- MAX_ADDR, 4, highest writable register address; addresses above it are rejected.
- SYNC_STAGES, 2, flip-flops in each input synchronizer before edge detection (minimum 2).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous active-low reset.
- nCS_in  input  1  SPI chip select pin, active low, asynchronous to clk.
- COPI_in  input  1  SPI data in, asynchronous.
- SCLK_in  input  1  SPI clock pin, asynchronous.
- en_reg_out_7_0  output  8  reg 0x00: output enables for out[7:0].
- en_reg_out_15_8  output  8  reg 0x01: output enables for out[15:8].
- en_reg_pwm_7_0  output  8  reg 0x02: PWM mode enables for out[7:0].
- en_reg_pwm_15_8  output  8  reg 0x03: PWM mode enables for out[15:8].
- pwm_duty_cycle  output  8  reg 0x04: shared duty cycle (0x00 = 0%, 0xFF = 100%).
- wr_pulse  output  1  one-cycle strobe when a register is written.
- err_pulse  output  1  one-cycle strobe when a frame is rejected.
- err_count  output  8  count of rejected frames, saturating.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-low (rst_n).
- Reset: all five registers = 0x00, wr_pulse = 0, err_pulse = 0, err_count = 0, state = IDLE, shift register and bit counter cleared, synchronizer flops = 1 for nCS and 0 for SCLK/COPI.
- Synchronizers:
  - Each pin passes through SYNC_STAGES flops plus one history flop.
  - Rising/falling edge = last sync stage differs from the history flop.
  - COPI is taken from its last sync stage, so it is aligned with the SCLK edge.
- Timing requirement: SCLK high and low phases each ≥ SYNC_STAGES+1 clk periods. Faster SCLK is not supported and is not detected.
- Frame format: MSB first. bit15 = R/W (1 = write), bits14:8 = address, bits7:0 = data. Shift occurs on SCLK rising edge only.
- State machine:
  - IDLE: on nCS falling edge, clear shift register and counter, go to SHIFT. SCLK edges are ignored in IDLE.
  - SHIFT: on each SCLK rise, shift COPI into the LSB and increment bit_cnt. When an SCLK rise arrives with bit_cnt == FRAME_BITS, go to OVERRUN. On nCS rise, evaluate the frame and go to IDLE.
  - OVERRUN: ignore SCLK. On nCS rise, reject the frame and go to IDLE.
- Frame evaluation on nCS rise:
  - Accept only if bit_cnt == 16, R/W = 1 and address ≤ MAX_ADDR. Write the data byte to the addressed register and assert wr_pulse.
  - Otherwise (short frame, R/W = 0, bad address, overrun): no register change; assert err_pulse; err_count += 1, saturating at 0xFF.
- Latency: the register value and wr_pulse/err_pulse become visible after the (SYNC_STAGES+1)th rising clk edge, counting the edge that first samples nCS_in high. With the default this is 3 edges. Pulses are exactly one cycle wide.
- Simultaneous events:
  - nCS rise and SCLK rise detected in the same cycle: nCS wins; no shift.
  - nCS fall and SCLK rise in the same cycle: SCLK edge ignored.
- nCS glitch: a fall then rise with zero SCLK edges is a short frame and is rejected (err_pulse).
- Reset mid-frame: the frame is discarded and the state returns to IDLE. Further SCLK edges are ignored until the next nCS falling edge. Registers read 0x00.
- Registers hold their value indefinitely between writes. Rewriting the same value still asserts wr_pulse.

Decomposition:
- Package spi_reg_pkg holds:
  - FRAME_BITS.
  - Address constants ADDR_EN_OUT_LO = 0, ADDR_EN_OUT_HI = 1, ADDR_EN_PWM_LO = 2, ADDR_EN_PWM_HI = 3, ADDR_DUTY = 4.
  - State enum {IDLE, SHIFT, OVERRUN}.
- One sub-module, sync_edge: parameterised synchronizer with rise/fall outputs, instantiated once per pin.

Test Plan:
- Reset, then write frame 0x80F0 (addr 0, data 0xF0) → en_reg_out_7_0 = 0xF0 exactly 3 clk edges after nCS high is sampled; wr_pulse high for 1 cycle; other registers stay 0x00.
- Write 0x84_80 to duty (addr 4), then 0x83_AA → pwm_duty_cycle = 0x80, en_reg_pwm_15_8 = 0xAA, err_count = 0.
- Frame 0x8555 (addr 5), then read frame 0x0012, then a 15-bit frame → no register changes; err_pulse ×3; err_count = 3.
- 17-bit frame whose first 16 bits are 0x8111 → OVERRUN; en_reg_out_15_8 stays 0x00; err_count increments by 1.
- Assert rst_n = 0 after 8 bits of 0x8222, release, clock the remaining 8 bits without toggling nCS → all registers 0x00, no wr_pulse; next full frame 0x8233 → en_reg_pwm_7_0 = 0x33.
- Send 300 bad frames → err_count saturates at 0xFF; a subsequent valid frame is still accepted.
